// File: rtl/execute_muldiv_pkg.sv
// Shared encodings for the execute-stage multiply/divide sequencer.
// Opcode and FSM state constants live here so decode and execute agree on them.
package execute_muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_CALC = 2'b01;
  localparam logic [1:0] ST_FIX  = 2'b10;
  localparam logic [1:0] ST_DONE = 2'b11;

  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_ACC_WIDTH  = 2 * DEF_DATA_WIDTH + 1;

  // Signed variants have opcode bit 0 clear.
  function automatic logic is_signed_op(input logic [1:0] op);
    return ~op[0];
  endfunction

endpackage

// File: rtl/execute_muldiv_step.sv
// One iteration of the multiply (add-then-shift-right) or restoring divide
// (shift-left-then-trial-subtract) datapath over the {hi, lo} accumulator.
module execute_muldiv_step #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                    is_div,
  input  logic [2*DATA_WIDTH:0]   acc_in,
  input  logic [DATA_WIDTH-1:0]   operand,
  output logic [2*DATA_WIDTH:0]   acc_out
);

  logic [DATA_WIDTH:0]   mul_upper;
  logic [2*DATA_WIDTH:0] div_shift;
  logic [DATA_WIDTH:0]   div_diff;

  always_comb begin
    mul_upper = acc_in[2*DATA_WIDTH:DATA_WIDTH];
    if (acc_in[0]) begin
      mul_upper = acc_in[2*DATA_WIDTH:DATA_WIDTH] + {1'b0, operand};
    end
    div_shift = {acc_in[2*DATA_WIDTH-1:0], 1'b0};
    // A set borrow bit means the trial subtraction went negative: restore.
    div_diff  = div_shift[2*DATA_WIDTH:DATA_WIDTH] - {1'b0, operand};
    if (is_div) begin
      acc_out = div_diff[DATA_WIDTH] ? div_shift
                                     : {div_diff, div_shift[DATA_WIDTH-1:1], 1'b1};
    end else begin
      acc_out = {1'b0, mul_upper, acc_in[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/execute_muldiv_sequencer.sv
// Multi-cycle mul/div controller: runs DATA_WIDTH iterations on magnitudes,
// fixes signs, then pulses done/write-back while stalling the pipe meanwhile.
module execute_muldiv_sequencer
  import execute_muldiv_pkg::*;
#(
  parameter int DATA_WIDTH       = 32,
  parameter int W_REG_ADDR_WIDTH = 5,
  parameter int MD_OPCODE_WIDTH  = 2,
  parameter int CNT_WIDTH        = 6
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start_in,
  input  logic [MD_OPCODE_WIDTH-1:0]  md_opcode_in,
  input  logic [DATA_WIDTH-1:0]       data_a_in,
  input  logic [DATA_WIDTH-1:0]       data_b_in,
  input  logic [W_REG_ADDR_WIDTH-1:0] w_reg_addr_in,
  input  logic                        flush_in,
  output logic                        stall_out,
  output logic                        busy_out,
  output logic                        done_out,
  output logic [DATA_WIDTH-1:0]       lo_data_out,
  output logic [DATA_WIDTH-1:0]       hi_data_out,
  output logic                        div_zero_out,
  output logic                        w_reg_wr_en_out,
  output logic [W_REG_ADDR_WIDTH-1:0] w_reg_addr_out
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DATA_WIDTH - 1);

  logic [1:0]                  state_reg, state_next;
  logic [CNT_WIDTH-1:0]        cnt_reg;
  logic [2*DATA_WIDTH:0]       acc_reg, step_acc;
  logic [DATA_WIDTH-1:0]       operand_reg;
  logic [1:0]                  op_reg;
  logic                        sign_a_reg, sign_b_reg, div_zero_reg;
  logic [DATA_WIDTH-1:0]       lo_reg, hi_reg;
  logic [W_REG_ADDR_WIDTH-1:0] addr_reg;

  logic [1:0]              op_in;
  logic                    accept, div_by_zero, a_neg, b_neg;
  logic [DATA_WIDTH-1:0]   a_abs, b_abs;
  logic [2*DATA_WIDTH-1:0] prod_fix;
  logic [DATA_WIDTH-1:0]   fix_lo, fix_hi;

  assign op_in       = md_opcode_in[1:0];
  assign accept      = (state_reg == ST_IDLE) && start_in && !flush_in;
  assign div_by_zero = op_in[1] && (data_b_in == '0);
  assign a_neg       = is_signed_op(op_in) && data_a_in[DATA_WIDTH-1];
  assign b_neg       = is_signed_op(op_in) && data_b_in[DATA_WIDTH-1];
  assign a_abs       = a_neg ? -data_a_in : data_a_in;
  assign b_abs       = b_neg ? -data_b_in : data_b_in;

  execute_muldiv_step #(.DATA_WIDTH(DATA_WIDTH)) u_step (
    .is_div  (op_reg[1]),
    .acc_in  (acc_reg),
    .operand (operand_reg),
    .acc_out (step_acc)
  );

  // Sign correction: quotient follows sign(a)^sign(b), remainder follows the dividend.
  always_comb begin
    prod_fix = acc_reg[2*DATA_WIDTH-1:0];
    if ((op_reg == MD_MULT) && (sign_a_reg ^ sign_b_reg)) begin
      prod_fix = -acc_reg[2*DATA_WIDTH-1:0];
    end
    if (op_reg[1]) begin
      fix_lo = ((op_reg == MD_DIV) && (sign_a_reg ^ sign_b_reg)) ? -acc_reg[DATA_WIDTH-1:0]
                                                                 : acc_reg[DATA_WIDTH-1:0];
      fix_hi = ((op_reg == MD_DIV) && sign_a_reg) ? -acc_reg[2*DATA_WIDTH-1:DATA_WIDTH]
                                                  : acc_reg[2*DATA_WIDTH-1:DATA_WIDTH];
    end else begin
      fix_lo = prod_fix[DATA_WIDTH-1:0];
      fix_hi = prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
    end
  end

  always_comb begin
    state_next = state_reg;
    if (flush_in) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (start_in) state_next = div_by_zero ? ST_DONE : ST_CALC;
        ST_CALC: if (cnt_reg == '0) state_next = ST_FIX;
        ST_FIX:  state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      operand_reg  <= '0;
      op_reg       <= '0;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      div_zero_reg <= 1'b0;
      lo_reg       <= '0;
      hi_reg       <= '0;
      addr_reg     <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        op_reg      <= op_in;
        addr_reg    <= w_reg_addr_in;
        sign_a_reg  <= a_neg;
        sign_b_reg  <= b_neg;
        cnt_reg     <= CNT_LAST;
        operand_reg <= op_in[1] ? b_abs : a_abs;
        acc_reg     <= {{(DATA_WIDTH+1){1'b0}}, (op_in[1] ? a_abs : b_abs)};
        if (div_by_zero) begin
          lo_reg       <= '1;
          hi_reg       <= data_a_in;
          div_zero_reg <= 1'b1;
        end
      end else if ((state_reg == ST_CALC) && !flush_in) begin
        acc_reg <= step_acc;
        if (cnt_reg != '0) cnt_reg <= cnt_reg - CNT_WIDTH'(1);
      end else if ((state_reg == ST_FIX) && !flush_in) begin
        lo_reg       <= fix_lo;
        hi_reg       <= fix_hi;
        div_zero_reg <= 1'b0;
      end
    end
  end

  assign stall_out       = accept || (state_reg == ST_CALC) || (state_reg == ST_FIX);
  assign busy_out        = (state_reg != ST_IDLE);
  assign done_out        = (state_reg == ST_DONE) && !flush_in;
  assign w_reg_wr_en_out = done_out;
  assign lo_data_out     = lo_reg;
  assign hi_data_out     = hi_reg;
  assign div_zero_out    = div_zero_reg;
  assign w_reg_addr_out  = addr_reg;

endmodule

// File: tb/tb_execute_muldiv_sequencer.sv
// Directed bench for the mul/div sequencer: results, latency, stall window,
// divide-by-zero, flush, busy-ignore and asynchronous reset.
module tb_execute_muldiv_sequencer;

  logic        clk;
  logic        rst_n;
  logic        start_in;
  logic [1:0]  md_opcode_in;
  logic [31:0] data_a_in;
  logic [31:0] data_b_in;
  logic [4:0]  w_reg_addr_in;
  logic        flush_in;
  logic        stall_out;
  logic        busy_out;
  logic        done_out;
  logic [31:0] lo_data_out;
  logic [31:0] hi_data_out;
  logic        div_zero_out;
  logic        w_reg_wr_en_out;
  logic [4:0]  w_reg_addr_out;

  int checks = 0;
  int errors = 0;

  execute_muldiv_sequencer dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .start_in        (start_in),
    .md_opcode_in    (md_opcode_in),
    .data_a_in       (data_a_in),
    .data_b_in       (data_b_in),
    .w_reg_addr_in   (w_reg_addr_in),
    .flush_in        (flush_in),
    .stall_out       (stall_out),
    .busy_out        (busy_out),
    .done_out        (done_out),
    .lo_data_out     (lo_data_out),
    .hi_data_out     (hi_data_out),
    .div_zero_out    (div_zero_out),
    .w_reg_wr_en_out (w_reg_wr_en_out),
    .w_reg_addr_out  (w_reg_addr_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Issue one operation and follow it to its done pulse. A nonzero poke_cycle
  // re-pulses start with different operands while the unit is busy.
  task automatic do_op(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] addr,
                       input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                       input logic exp_dz, input int exp_lat, input int poke_cycle);
    int lat;
    int stall_cnt;
    bit seen;
    @(negedge clk);
    start_in = 1'b1; md_opcode_in = op; data_a_in = a; data_b_in = b; w_reg_addr_in = addr;
    #1;
    check_val({tag, " stall_at_start"}, stall_out, 1);
    @(negedge clk);
    start_in = 1'b0;
    lat = 1; stall_cnt = 1; seen = 0;
    while (!seen && lat < 100) begin
      if (done_out) begin
        seen = 1;
      end else begin
        if (stall_out) stall_cnt++;
        @(negedge clk);
        lat++;
        start_in = (lat == poke_cycle);
        if (lat == poke_cycle) begin
          md_opcode_in = 2'b01; data_a_in = 32'd100; data_b_in = 32'd100; w_reg_addr_in = 5'd4;
        end
      end
    end
    start_in = 1'b0;
    check_val({tag, " latency"}, lat, exp_lat);
    check_val({tag, " stall_cycles"}, stall_cnt, exp_lat);
    check_val({tag, " lo"}, lo_data_out, exp_lo);
    check_val({tag, " hi"}, hi_data_out, exp_hi);
    check_val({tag, " div_zero"}, div_zero_out, exp_dz);
    check_val({tag, " wr_en"}, w_reg_wr_en_out, 1);
    check_val({tag, " addr"}, w_reg_addr_out, addr);
    check_val({tag, " stall_in_done"}, stall_out, 0);
    $display("op %s: a=0x%08h b=0x%08h lo=0x%08h hi=0x%08h dz=%0b latency=%0d",
             tag, a, b, lo_data_out, hi_data_out, div_zero_out, lat);
    @(negedge clk);
    check_val({tag, " done_pulse_end"}, done_out, 0);
    check_val({tag, " busy_after"}, busy_out, 0);
  endtask

  initial begin
    int done_seen;
    rst_n = 1'b0; start_in = 1'b0; md_opcode_in = 2'b00; data_a_in = '0; data_b_in = '0;
    w_reg_addr_in = '0; flush_in = 1'b0;
    repeat (3) @(negedge clk);
    check_val("reset busy", busy_out, 0);
    check_val("reset done", done_out, 0);
    check_val("reset lo", lo_data_out, 0);
    check_val("reset hi", hi_data_out, 0);
    rst_n = 1'b1;

    do_op("MULTU_max_x2", 2'b01, 32'hFFFFFFFF, 32'h2, 5'd1, 32'hFFFFFFFE, 32'h1, 1'b0, 34, 0);
    do_op("MULT_neg3_x5", 2'b00, 32'hFFFFFFFD, 32'h5, 5'd9, 32'hFFFFFFF1, 32'hFFFFFFFF, 1'b0, 34, 0);
    do_op("DIV_neg7_by2", 2'b10, 32'hFFFFFFF9, 32'h2, 5'd10, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 34, 0);
    do_op("DIVU_100_by7", 2'b11, 32'd100, 32'd7, 5'd11, 32'd14, 32'd2, 1'b0, 34, 0);
    do_op("DIVU_by_zero", 2'b11, 32'hA, 32'h0, 5'd12, 32'hFFFFFFFF, 32'hA, 1'b1, 1, 0);
    do_op("DIV_overflow", 2'b10, 32'h80000000, 32'hFFFFFFFF, 5'd13, 32'h80000000, 32'h0, 1'b0, 34, 0);
    do_op("MULT_min_sq", 2'b00, 32'h80000000, 32'h80000000, 5'd14, 32'h0, 32'h40000000, 1'b0, 34, 0);
    do_op("DIV_7_byneg2", 2'b10, 32'd7, 32'hFFFFFFFE, 5'd15, 32'hFFFFFFFD, 32'h1, 1'b0, 34, 0);

    // Flush during CALC cycle 10: no done, previous results retained.
    @(negedge clk);
    start_in = 1'b1; md_opcode_in = 2'b01; data_a_in = 32'd3; data_b_in = 32'd4; w_reg_addr_in = 5'd20;
    @(negedge clk);
    start_in = 1'b0;
    repeat (9) @(negedge clk);
    flush_in = 1'b1;
    #1;
    check_val("flush done_masked", done_out, 0);
    @(negedge clk);
    flush_in = 1'b0;
    check_val("flush busy", busy_out, 0);
    check_val("flush stall", stall_out, 0);
    check_val("flush lo_kept", lo_data_out, 32'hFFFFFFFD);
    check_val("flush hi_kept", hi_data_out, 32'h1);
    done_seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_out) done_seen++;
    end
    check_val("flush no_done", done_seen, 0);
    $display("op flush: aborted MULTU 3x4, lo=0x%08h hi=0x%08h kept", lo_data_out, hi_data_out);
    do_op("MULTU_3x4", 2'b01, 32'd3, 32'd4, 5'd21, 32'd12, 32'd0, 1'b0, 34, 0);

    // Second start while busy is ignored.
    do_op("MULTU_busy_ign", 2'b01, 32'd6, 32'd7, 5'd3, 32'd42, 32'd0, 1'b0, 34, 5);

    // Asynchronous reset mid-CALC.
    @(negedge clk);
    start_in = 1'b1; md_opcode_in = 2'b01; data_a_in = 32'd9; data_b_in = 32'd9; w_reg_addr_in = 5'd7;
    @(negedge clk);
    start_in = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_val("rst busy", busy_out, 0);
    check_val("rst stall", stall_out, 0);
    check_val("rst done", done_out, 0);
    check_val("rst lo", lo_data_out, 0);
    check_val("rst hi", hi_data_out, 0);
    check_val("rst div_zero", div_zero_out, 0);
    check_val("rst wr_en", w_reg_wr_en_out, 0);
    check_val("rst addr", w_reg_addr_out, 0);
    $display("op reset: outputs cleared mid-CALC");
    @(negedge clk);
    rst_n = 1'b1;
    do_op("MULTU_5x5", 2'b01, 32'd5, 32'd5, 5'd2, 32'd25, 32'd0, 1'b0, 34, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
